// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and a Busy stall flag.
// Optional madd/maddu/msub/msubu support is compiled in when MDU_MADD_EN is defined.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MDCtrl,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    op_q, op_d;
   logic [31:0]   a_q, a_d, b_q, b_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;

   logic          issue_mul, issue_div;
   logic [63:0]   prod_s, prod_u, acc;
   logic          div_signed;
   logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

   assign Busy = (state_q == RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

   // Result datapath works on the latched operands so it is stable for the whole run.
   always_comb begin
      prod_u     = {32'b0, a_q} * {32'b0, b_q};
      prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      acc        = {hi_q, lo_q};
      div_signed = (op_q == OP_DIV);
      a_mag      = (div_signed && a_q[31]) ? -a_q : a_q;
      b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;
      b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag      = a_mag / b_safe;
      r_mag      = a_mag % b_safe;
      // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
      quot       = (div_signed && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
      rem        = (div_signed && a_q[31]) ? -r_mag : r_mag;
   end

   always_comb begin
      issue_mul = 1'b0;
      issue_div = 1'b0;
      if (Start && (state_q == IDLE)) begin
         case (MDCtrl)
            OP_MULT, OP_MULTU: issue_mul = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: issue_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU:   issue_div = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (issue_mul || issue_div) begin
               op_d    = MDCtrl;
               a_d     = SrcA;
               b_d     = SrcB;
               cnt_d   = issue_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
               state_d = RUN;
            end else if (Start && (MDCtrl == OP_MTHI)) begin
               hi_d = SrcA;
            end else if (Start && (MDCtrl == OP_MTLO)) begin
               lo_d = SrcA;
            end
         end
         RUN: begin
            if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_DIV, OP_DIVU: begin
                     if (b_q != 32'd0) begin
                        lo_d = quot;
                        hi_d = rem;
                     end
                  end
`ifdef MDU_MADD_EN
                  OP_MADD:  {hi_d, lo_d} = acc + prod_s;
                  OP_MADDU: {hi_d, lo_d} = acc + prod_u;
                  OP_MSUB:  {hi_d, lo_d} = acc - prod_s;
                  OP_MSUBU: {hi_d, lo_d} = acc - prod_u;
`endif
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed scenarios plus random ops against a plain-arithmetic HI/LO model.
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [3:0]  MDCtrl;
   logic [31:0] SrcA, SrcB;
   logic        Busy;
   logic [31:0] HI, LO;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] exp_q[$];

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDCtrl(MDCtrl),
      .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   // Architectural effect of one issued op from IDLE; n is the expected Busy length.
   task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo,
                           output logic [31:0] nh, output logic [31:0] nl, output int n);
      longint          ps, sq, sr;
      longint unsigned pu, acc, r;
      ps  = longint'($signed(a)) * longint'($signed(b));
      pu  = {32'b0, a} * {32'b0, b};
      acc = {hi, lo};
      nh  = hi;
      nl  = lo;
      n   = 0;
      r   = 64'd0;
      case (op)
         4'd1: begin r = ps; nh = r[63:32]; nl = r[31:0]; n = MC; end
         4'd2: begin r = pu; nh = r[63:32]; nl = r[31:0]; n = MC; end
         4'd3: begin
            n = DC;
            if (b != 32'd0) begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               nl = sq[31:0];
               nh = sr[31:0];
            end
         end
         4'd4: begin
            n = DC;
            if (b != 32'd0) begin
               nl = a / b;
               nh = a % b;
            end
         end
         4'd5: nh = a;
         4'd6: nl = a;
`ifdef MDU_MADD_EN
         4'd7:  begin r = acc + ps; nh = r[63:32]; nl = r[31:0]; n = MC; end
         4'd8:  begin r = acc + pu; nh = r[63:32]; nl = r[31:0]; n = MC; end
         4'd9:  begin r = acc - ps; nh = r[63:32]; nl = r[31:0]; n = MC; end
         4'd10: begin r = acc - pu; nh = r[63:32]; nl = r[31:0]; n = MC; end
`endif
         default: ;
      endcase
   endtask

   // Called just after a negedge with the DUT idle; returns at the first idle negedge.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
      logic [31:0] eh, el;
      logic [63:0] e;
      int          exp_n, n;
      model_op(op, a, b, m_hi, m_lo, eh, el, exp_n);
      exp_q.push_back({eh, el});
      Start = 1'b1; MDCtrl = op; SrcA = a; SrcB = b;
      @(negedge clk);
      Start = 1'b0; MDCtrl = 4'($urandom_range(0, 15)); SrcA = $urandom; SrcB = $urandom;
      n = 0;
      while (Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      MDCtrl = 4'd0;
      e = exp_q.pop_front();
      total++;
      if (n != exp_n) begin
         bad++;
         $display("FAIL %s busy_len: got %0d exp %0d", name, n, exp_n);
      end
      total++;
      if (HI !== e[63:32]) begin
         bad++;
         $display("FAIL %s HI: got %h exp %h (op %0d a %h b %h)", name, HI, e[63:32], op, a, b);
      end
      total++;
      if (LO !== e[31:0]) begin
         bad++;
         $display("FAIL %s LO: got %h exp %h (op %0d a %h b %h)", name, LO, e[31:0], op, a, b);
      end
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b1; MDCtrl = 4'd5; SrcA = 32'hFFFF_0000; SrcB = 32'd1;
      repeat (3) @(negedge clk);
      reset = 1'b0; Start = 1'b0; MDCtrl = 4'd0;
      total++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         bad++;
         $display("FAIL reset: got busy=%b hi=%h lo=%h exp 0/0/0", Busy, HI, LO);
      end
      m_hi = 32'd0;
      m_lo = 32'd0;
   endtask

   task automatic test_mult();
      run_op(4'd1, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
      total++;
      if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         bad++;
         $display("FAIL mult_const: got %h%h exp fffffffffffffffa", HI, LO);
      end
      run_op(4'd2, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
      total++;
      if ({HI, LO} !== 64'h0000_0002_FFFF_FFFA) begin
         bad++;
         $display("FAIL multu_const: got %h%h exp 00000002fffffffa", HI, LO);
      end
   endtask

   task automatic test_div();
      run_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, "div");
      total++;
      if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL div_const: got hi=%h lo=%h exp ffffffff/fffffffd", HI, LO);
      end
      run_op(4'd4, 32'd7, 32'd2, "divu");
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      total++;
      if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
         bad++;
         $display("FAIL div_ovf_const: got hi=%h lo=%h exp 0/80000000", HI, LO);
      end
      run_op(4'd3, 32'd9, 32'hFFFF_FFFC, "div_neg_divisor");
   endtask

   task automatic test_mthi_mtlo();
      run_op(4'd5, 32'h1234_5678, 32'd0, "mthi");
      run_op(4'd6, 32'h9ABC_DEF0, 32'd0, "mtlo");
      run_op(4'd4, 32'd5, 32'd0, "divu_by_zero");
      run_op(4'd3, 32'hFFFF_FF00, 32'd0, "div_by_zero");
      total++;
      if (HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0) begin
         bad++;
         $display("FAIL div0_hold: got hi=%h lo=%h exp 12345678/9abcdef0", HI, LO);
      end
      run_op(4'd0, 32'h5555_5555, 32'd1, "none_op");
`ifndef MDU_MADD_EN
      run_op(4'd7, 32'd3, 32'd3, "reserved7");
      run_op(4'd15, 32'd3, 32'd3, "reserved15");
`endif
   endtask

   task automatic test_start_ignored();
      int n;
      n = 0;
      Start = 1'b1; MDCtrl = 4'd1; SrcA = 32'd3; SrcB = 32'd4;
      @(negedge clk);
      if (Busy === 1'b1) n++;
      MDCtrl = 4'd3; SrcA = 32'd50; SrcB = 32'd3;
      @(negedge clk);
      if (Busy === 1'b1) n++;
      MDCtrl = 4'd6; SrcA = 32'h0000_DEAD;
      @(negedge clk);
      Start = 1'b0; MDCtrl = 4'd0;
      while (Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      total++;
      if (n != MC) begin
         bad++;
         $display("FAIL ignore_busy_len: got %0d exp %0d", n, MC);
      end
      total++;
      if (HI !== 32'd0 || LO !== 32'd12) begin
         bad++;
         $display("FAIL ignore_result: got hi=%h lo=%h exp 0/0000000c", HI, LO);
      end
      m_hi = 32'd0;
      m_lo = 32'd12;
   endtask

   task automatic test_reset_mid();
      run_op(4'd5, 32'hAAAA_0001, 32'd0, "pre_reset_mthi");
      Start = 1'b1; MDCtrl = 4'd3; SrcA = 32'd100; SrcB = 32'd7;
      @(negedge clk);
      Start = 1'b0; MDCtrl = 4'd0;
      repeat (3) @(negedge clk);
      total++;
      if (Busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_busy4: got %b exp 1", Busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid: got busy=%b hi=%h lo=%h exp 0/0/0", Busy, HI, LO);
      end
      m_hi = 32'd0;
      m_lo = 32'd0;
      run_op(4'd1, 32'd2, 32'd2, "post_reset_mult");
      total++;
      if (LO !== 32'd4) begin
         bad++;
         $display("FAIL post_reset_lo: got %h exp 4", LO);
      end
   endtask

`ifdef MDU_MADD_EN
   task automatic test_madd();
      run_op(4'd5, 32'd0, 32'd0, "madd_mthi");
      run_op(4'd6, 32'hFFFF_FFFF, 32'd0, "madd_mtlo");
      run_op(4'd8, 32'd1, 32'd1, "maddu");
      total++;
      if (HI !== 32'd1 || LO !== 32'd0) begin
         bad++;
         $display("FAIL maddu_const: got hi=%h lo=%h exp 1/0", HI, LO);
      end
      run_op(4'd9, 32'd1, 32'd2, "msub");
      total++;
      if (HI !== 32'd0 || LO !== 32'hFFFF_FFFE) begin
         bad++;
         $display("FAIL msub_const: got hi=%h lo=%h exp 0/fffffffe", HI, LO);
      end
      run_op(4'd7, 32'hFFFF_FFFF, 32'd5, "madd");
      run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu");
   endtask
`endif

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         run_op(op, rand_operand(), rand_operand(), "random");
      end
   endtask

   initial begin
      reset = 1'b0; Start = 1'b0; MDCtrl = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
      @(negedge clk);
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_start_ignored();
      test_reset_mid();
`ifdef MDU_MADD_EN
      test_madd();
`endif
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
